// File: rtl/la_rxdiff_pkg.sv
// Shared types for the differential receiver conditioner: FSM states,
// symbol codes and the zp/zn pair classification.
package la_rxdiff_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_ACQ   = 2'd1,
      ST_LOCK  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SYM_ZERO = 2'd0,
      SYM_ONE  = 2'd1,
      SYM_INV  = 2'd2
   } sym_t;

   // {zp, zn} encodings of the two legal differential states
   localparam logic [1:0] PAIR_ONE  = 2'b10;
   localparam logic [1:0] PAIR_ZERO = 2'b01;

   function automatic sym_t classify(input logic p, input logic n);
      sym_t s;
      case ({p, n})
         PAIR_ONE:  s = SYM_ONE;
         PAIR_ZERO: s = SYM_ZERO;
         default:   s = SYM_INV;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/la_rxdiff_if.sv
// Pad-side and core-side signal bundle of la_rxdiff_filter.
// slave = the conditioner, master = whatever drives en/clr and the pad legs.
interface la_rxdiff_if #(
   parameter int CNTW = 8
);
   logic            en;
   logic            ie;
   logic            zp;
   logic            zn;
   logic            clr;
   logic            z;
   logic            valid;
   logic            err;
   logic [CNTW-1:0] errcnt;
   logic            rise;
   logic            fall;

   modport slave (
      input  en, zp, zn, clr,
      output ie, z, valid, err, errcnt, rise, fall
   );

   modport master (
      output en, zp, zn, clr,
      input  ie, z, valid, err, errcnt, rise, fall
   );
endinterface

// File: rtl/la_rxdiff_sync.sv
// SYNCW-deep single-bit synchronizer with synchronous clear.
module la_rxdiff_sync #(
   parameter int SYNCW = 2
) (
   input  logic clk,
   input  logic srst,
   input  logic d,
   output logic q
);
   logic [SYNCW-1:0] sync_reg;

   generate
      for (genvar gi = 0; gi < SYNCW; gi++) begin : g_stage
         always_ff @(posedge clk) begin
            if (srst)
               sync_reg[gi] <= 1'b0;
            else if (gi == 0)
               sync_reg[gi] <= d;
            else
               sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
         end
      end
   endgenerate

   assign q = sync_reg[SYNCW-1];
endmodule

// File: rtl/la_rxdiff_filter.sv
// Differential receiver conditioner: sync, classify, glitch-filter, lock FSM.
// Define LA_RXDIFF_EDGE_EN to build the rise/fall edge pulse outputs.
module la_rxdiff_filter
   import la_rxdiff_pkg::*;
#(
   parameter int SYNCW = 2,
   parameter int FILT  = 4,
   parameter int CNTW  = 8
) (
   input  logic       clk,
   input  logic       rst,
   la_rxdiff_if.slave bus
);
   localparam int            CW      = (FILT > 1) ? $clog2(FILT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

   logic            sync_clr, zp_s, zn_s;
   sym_t            sym, cand_reg, cand_next;
   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic            filter_run, commit, data_commit, inv_commit, fault_entry;
   logic            ie_reg, z_reg, z_next, err_reg, valid;
   logic [CNTW-1:0] errcnt_reg;

   // Legs are meaningless while the receiver is disabled, so the
   // synchronizers restart from zero on every enable.
   assign sync_clr = rst | ~bus.en;

   la_rxdiff_sync #(.SYNCW(SYNCW)) u_sync_p (.clk(clk), .srst(sync_clr), .d(bus.zp), .q(zp_s));
   la_rxdiff_sync #(.SYNCW(SYNCW)) u_sync_n (.clk(clk), .srst(sync_clr), .d(bus.zn), .q(zn_s));

   assign sym        = classify(zp_s, zn_s);
   assign filter_run = bus.en && (state_reg != ST_OFF);

   // cnt holds run length minus one; a commit fires on every sample that
   // completes (or extends) a run of FILT identical symbols.
   always_comb begin
      cand_next = cand_reg;
      cnt_next  = cnt_reg;
      commit    = 1'b0;
      if (!filter_run) begin
         cand_next = SYM_INV;
         cnt_next  = '0;
      end else if (sym != cand_reg) begin
         cand_next = sym;
         cnt_next  = '0;
         commit    = (FILT == 1);
      end else begin
         if (cnt_reg != CNT_MAX)
            cnt_next = cnt_reg + 1'b1;
         commit = (cnt_next == CNT_MAX);
      end
   end

   assign data_commit = commit && (cand_next != SYM_INV);
   assign inv_commit  = commit && (cand_next == SYM_INV);
   assign fault_entry = inv_commit && ((state_reg == ST_ACQ) || (state_reg == ST_LOCK));

   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= ST_OFF;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (!bus.en) begin
         state_next = ST_OFF;
      end else begin
         case (state_reg)
            ST_OFF: state_next = ST_ACQ;
            ST_ACQ, ST_LOCK, ST_FAULT: begin
               if (data_commit)
                  state_next = ST_LOCK;
               else if (inv_commit)
                  state_next = ST_FAULT;
            end
            default: state_next = ST_OFF;
         endcase
      end
   end

   always_comb begin
      valid = (state_reg == ST_LOCK);
   end

   always_comb begin
      z_next = z_reg;
      if (!bus.en)
         z_next = 1'b0;
      else if (data_commit)
         z_next = (cand_next == SYM_ONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ie_reg     <= 1'b0;
         z_reg      <= 1'b0;
         cand_reg   <= SYM_INV;
         cnt_reg    <= '0;
         err_reg    <= 1'b0;
         errcnt_reg <= '0;
      end else begin
         ie_reg   <= bus.en;
         z_reg    <= z_next;
         cand_reg <= cand_next;
         cnt_reg  <= cnt_next;
         // A fault entry beats clr, so the coincident case reads as one fresh fault
         if (fault_entry) begin
            err_reg <= 1'b1;
            if (bus.clr)
               errcnt_reg <= CNTW'(1);
            else if (errcnt_reg != '1)
               errcnt_reg <= errcnt_reg + 1'b1;
         end else if (bus.clr) begin
            err_reg    <= 1'b0;
            errcnt_reg <= '0;
         end
      end
   end

   assign bus.ie     = ie_reg;
   assign bus.z      = z_reg;
   assign bus.valid  = valid;
   assign bus.err    = err_reg;
   assign bus.errcnt = errcnt_reg;

`ifdef LA_RXDIFF_EDGE_EN
   logic rise_reg, fall_reg;

   // Only data commits move z towards a pulse; the forced z=0 on disable does not.
   always_ff @(posedge clk) begin
      if (rst) begin
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
      end else begin
         rise_reg <= data_commit && z_next && !z_reg;
         fall_reg <= data_commit && !z_next && z_reg;
      end
   end

   assign bus.rise = rise_reg;
   assign bus.fall = fall_reg;
`else
   assign bus.rise = 1'b0;
   assign bus.fall = 1'b0;
`endif

endmodule
